cnn_frame_sequencer: RTL and testbench
======================================

// Module: cnn_frame_sequencer
// PURPOSE
// Parametrised frame-level controller for the CNN core (conv1/pool1/conv2/pool2/fc chain).
// Replaces the free-running "weights_load_start=1 / en=i_start" scheme with a start/busy/done FSM.
// Adds explicit weight-load phase, per-stage end tracking, watchdog, abort, continuous multi-frame mode
// and a 2-entry valid/ready result buffer between the fc stage and the SoC (NICE) side.
// PARAMETERS
// NUM_STAGES   5    number of pipeline stages tracked (conv1, pool1, conv2, pool2, fc)
// RES_W        5    classification result width
// FCNT_W       16   frame counter width
// TMO_W        20   watchdog counter width; timeout fires at 2**TMO_W-1 idle cycles
// PORTS
// i_clk          in   1           core clock (PE clock domain)
// i_rst_n        in   1           asynchronous active-low reset
// i_start        in   1           start pulse; sampled only in IDLE/DONE/TMO
// i_cont         in   1           continuous mode; sampled with i_start
// i_abort        in   1           abort pulse; highest priority
// o_wload_start  out  1           one-cycle pulse requesting weight loader start
// i_wload_done   in   1           weight loader finished (level)
// o_stage_en     out  NUM_STAGES  per-stage enable
// i_stage_act    in   NUM_STAGES  per-stage activity (any valid in/out), feeds watchdog
// i_stage_end    in   NUM_STAGES  per-stage end-of-frame pulse
// i_res          in   RES_W       fc result
// i_res_valid    in   1           fc result valid pulse
// o_res          out  RES_W       buffered result
// o_res_valid    out  1           buffer non-empty
// i_res_ready    in   1           consumer pops when o_res_valid & i_res_ready
// o_busy         out  1           high in WLOAD/RUN/WAIT
// o_done         out  1           one-cycle pulse when a single-shot frame completes
// o_timeout      out  1           sticky watchdog flag, cleared by accepted i_start
// o_frame_cnt    out  FCNT_W      completed frames since last accepted i_start (wraps)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; buffer empty; end flags, counters cleared.
// - States: IDLE, WLOAD, RUN, WAIT, DONE, TMO (encoding in package).
// - IDLE/DONE/TMO + i_start: latch i_cont, clear o_timeout/o_frame_cnt, pulse o_wload_start, -> WLOAD.
// - i_start in WLOAD/RUN/WAIT ignored. i_abort in any state: -> IDLE next cycle, o_stage_en=0,
//   buffer flushed, end flags cleared; abort beats simultaneous start/end/result.
// - WLOAD: o_stage_en=0; i_wload_done high -> RUN (o_stage_en all-ones from next cycle).
// - RUN: i_stage_end[k] sets sticky end_flag[k]. Frame complete = all end_flags set AND result pushed
//   (either order). On completion: o_frame_cnt+1, end flags cleared same cycle.
//   single-shot: o_stage_en=0, o_done pulse 1 cycle, -> DONE.
//   continuous: buffer not full -> stay RUN (next frame, no weight reload); full -> WAIT.
// - WAIT: o_stage_en=0; first cycle with a free buffer slot -> RUN.
// - Result buffer: 2-entry FIFO, push on i_res_valid in RUN, pop on valid&ready; push+pop same cycle
//   when full is legal (count unchanged); push while full (only possible off-protocol) dropped,
//   count unchanged. o_res is the head entry, zero-latency (registered storage, comb head mux).
//   Buffer is readable in every state except the cycle after abort.
// - Watchdog: in WLOAD/RUN counts cycles with no i_stage_act, no i_stage_end, no i_wload_done;
//   any such event clears it. Saturation -> o_stage_en=0, o_timeout=1, -> TMO. Not counted in WAIT.
// - Duplicate i_stage_end[k] before frame completion: no effect (flag already set).
// - o_frame_cnt wraps at 2**FCNT_W; all counters unsigned, no saturation except watchdog.
// STRUCTURE
// - Package cnn_ctrl_pkg: state enum, NUM_STAGES default, RES_W, FIFO depth constant (2).
// - One sub-module: cnn_res_fifo (2-entry valid/ready FIFO, RES_W wide, flush input).
// - FSM, end-flag register, watchdog and frame counter in this module.
// TESTING
// - Single-shot: start, wload_done after 10 cyc, 5 stage_end pulses, res=5'd7 -> o_done once,
//   o_res=7 valid until ready, o_frame_cnt=1, state DONE, o_stage_en=0.
// - Continuous, ready=0: three frames -> two buffered, third completion -> WAIT with
//   o_stage_en=0; one pop -> RUN next cycle; results pop in order 1,2,3.
// - Result before last stage_end and vice versa: completion counted exactly once each order.
// - Abort mid-RUN with 1 buffered result and 3 end flags set -> IDLE, o_res_valid=0, o_busy=0,
//   restart completes normally with o_frame_cnt=1.
// - Watchdog with TMO_W=4: no activity for 15 cycles in RUN -> o_timeout=1, TMO; i_start clears it.
// - Reset asserted mid-RUN asynchronously -> all outputs 0 immediately; start ignored while in WLOAD.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding and default sizes for the CNN frame controller
package cnn_ctrl_pkg;
    localparam int NUM_STAGES_DEF = 5;
    localparam int RES_W_DEF      = 5;
    localparam int FIFO_DEPTH     = 2;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_RUN,
        S_WAIT,
        S_DONE,
        S_TMO
    } state_t;
endpackage

// File: rtl/cnn_res_fifo.sv
// cnn_res_fifo: 2-entry valid/ready result buffer with zero-latency head and flush
module cnn_res_fifo
    import cnn_ctrl_pkg::*;
#(
    parameter int W = RES_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_cnt_nxt
);
    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;

    assign o_valid   = r_cnt != 2'd0;
    assign o_data    = o_valid ? r_mem[r_rp] : '0;
    assign w_pop     = o_valid & i_ready & ~i_flush;
    assign w_push    = i_push & ~i_flush & ((r_cnt != 2'(FIFO_DEPTH)) | w_pop);
    assign o_cnt_nxt = i_flush ? 2'd0 : r_cnt + 2'(w_push) - 2'(w_pop);

    // Storage and pointers; a push into a full buffer without a pop is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_mem[r_wp] <= i_data;
            r_wp  <= i_flush ? 1'b0 : r_wp ^ w_push;
            r_rp  <= i_flush ? 1'b0 : r_rp ^ w_pop;
            r_cnt <= o_cnt_nxt;
        end
    end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: start/busy/done frame controller with weight load, watchdog and result buffer
module cnn_frame_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF,
    parameter int RES_W      = RES_W_DEF,
    parameter int FCNT_W     = 16,
    parameter int TMO_W      = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_cont,
    input  logic                  i_abort,
    output logic                  o_wload_start,
    input  logic                  i_wload_done,
    output logic [NUM_STAGES-1:0] o_stage_en,
    input  logic [NUM_STAGES-1:0] i_stage_act,
    input  logic [NUM_STAGES-1:0] i_stage_end,
    input  logic [RES_W-1:0]      i_res,
    input  logic                  i_res_valid,
    output logic [RES_W-1:0]      o_res,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [FCNT_W-1:0]     o_frame_cnt
);
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cont;
    logic                  r_wload_start;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_got;
    logic [NUM_STAGES-1:0] r_flags;
    logic [TMO_W-1:0]      r_wdog;
    logic [FCNT_W-1:0]     r_fcnt;
    logic [NUM_STAGES-1:0] w_flags_nxt;
    logic [1:0]            w_cnt_nxt;
    logic                  w_full_nxt;
    logic                  w_run;
    logic                  w_start;
    logic                  w_push;
    logic                  w_got_nxt;
    logic                  w_complete;
    logic                  w_count;
    logic                  w_quiet;
    logic                  w_fire;
    logic                  w_keep;

    assign w_run       = r_state == S_RUN;
    assign w_start     = i_start & ~i_abort & (r_state inside {S_IDLE, S_DONE, S_TMO});
    assign w_push      = w_run & i_res_valid & ~i_abort;
    assign w_flags_nxt = r_flags | i_stage_end;
    assign w_got_nxt   = r_got | i_res_valid;
    assign w_complete  = w_run & ~i_abort & (&w_flags_nxt) & w_got_nxt;
    assign w_keep      = w_run & ~i_abort & ~w_complete;
    assign w_count     = (r_state == S_WLOAD) | w_run;
    assign w_quiet     = ~(|i_stage_act) & ~(|i_stage_end) & ~i_wload_done;
    assign w_fire      = w_count & w_quiet & ~i_abort & ~w_complete & (r_wdog == WDOG_LAST);
    assign w_full_nxt  = w_cnt_nxt == 2'(FIFO_DEPTH);

    assign o_stage_en    = {NUM_STAGES{w_run}};
    assign o_busy        = r_state inside {S_WLOAD, S_RUN, S_WAIT};
    assign o_wload_start = r_wload_start;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_frame_cnt   = r_fcnt;

    cnn_res_fifo #(.W(RES_W)) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_abort),
        .i_push   (w_push),
        .i_data   (i_res),
        .i_ready  (i_res_ready),
        .o_data   (o_res),
        .o_valid  (o_res_valid),
        .o_cnt_nxt(w_cnt_nxt)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: abort overrides all; completion beats the watchdog in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WLOAD: w_state_nxt = i_wload_done ? S_RUN : (w_fire ? S_TMO : S_WLOAD);
            S_RUN:   w_state_nxt = w_complete ? (!r_cont ? S_DONE : (w_full_nxt ? S_WAIT : S_RUN))
                                              : (w_fire ? S_TMO : S_RUN);
            S_WAIT:  w_state_nxt = w_full_nxt ? S_WAIT : S_RUN;
            default: w_state_nxt = w_start ? S_WLOAD : r_state;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
    end

    // Frame bookkeeping: end flags live only inside RUN, watchdog only in WLOAD/RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cont        <= 1'b0;
            r_wload_start <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_got         <= 1'b0;
            r_flags       <= '0;
            r_wdog        <= '0;
            r_fcnt        <= '0;
        end else begin
            r_cont        <= w_start ? i_cont : r_cont;
            r_wload_start <= w_start;
            r_done        <= w_complete & ~r_cont;
            r_timeout     <= w_start ? 1'b0 : (w_fire | r_timeout);
            r_got         <= w_keep & w_got_nxt;
            r_flags       <= w_keep ? w_flags_nxt : '0;
            r_wdog        <= (w_count & w_quiet & ~i_abort & ~w_complete & ~w_fire) ? r_wdog + TMO_W'(1) : '0;
            r_fcnt        <= w_start ? '0 : r_fcnt + FCNT_W'(w_complete);
        end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: directed and randomized checks against a behavioural frame-controller model
module tb_cnn_frame_sequencer;
    localparam int NS = 5;
    localparam int RW = 5;
    localparam int FW = 16;
    localparam int TW = 4;
    localparam int LIMIT = 2**TW - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          abort = 1'b0;
    logic          wload_done = 1'b0;
    logic          res_valid = 1'b0;
    logic          ready = 1'b0;
    logic [NS-1:0] act = '0;
    logic [NS-1:0] s_end = '0;
    logic [RW-1:0] res = '0;
    logic          wload_start, busy, done, timeout, res_o_valid;
    logic [NS-1:0] stage_en;
    logic [RW-1:0] res_o;
    logic [FW-1:0] fcnt;
    int            total = 0;
    int            bad = 0;

    string         ph;
    bit            m_cont, m_wls, m_done, m_tmo, m_got;
    int            m_fcnt, m_quiet;
    logic [NS-1:0] m_ends;
    int            q[$];

    cnn_frame_sequencer #(.NUM_STAGES(NS), .RES_W(RW), .FCNT_W(FW), .TMO_W(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cont(cont), .i_abort(abort),
        .o_wload_start(wload_start), .i_wload_done(wload_done), .o_stage_en(stage_en),
        .i_stage_act(act), .i_stage_end(s_end), .i_res(res), .i_res_valid(res_valid),
        .o_res(res_o), .o_res_valid(res_o_valid), .i_res_ready(ready), .o_busy(busy),
        .o_done(done), .o_timeout(timeout), .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = "IDLE";
        m_cont = 0; m_wls = 0; m_done = 0; m_tmo = 0; m_got = 0;
        m_fcnt = 0; m_quiet = 0; m_ends = '0;
        q.delete();
    endtask

    task automatic quiet_step(input bit ev);
        m_quiet = ev ? 0 : m_quiet + 1;
        if (m_quiet == LIMIT) begin
            m_tmo = 1; ph = "TMO"; m_ends = '0; m_got = 0; m_quiet = 0;
        end
    endtask

    task automatic model_step();
        bit ev;
        ev = (|act) || (|s_end) || wload_done;
        m_wls = 0;
        m_done = 0;
        if (abort) begin
            q.delete(); m_ends = '0; m_got = 0; m_quiet = 0; ph = "IDLE";
            return;
        end
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (ph == "IDLE" || ph == "DONE" || ph == "TMO") begin
            if (start) begin
                m_cont = cont; m_tmo = 0; m_fcnt = 0; m_wls = 1; m_quiet = 0; ph = "WLOAD";
            end
        end else if (ph == "WLOAD") begin
            if (wload_done) begin ph = "RUN"; m_quiet = 0; end
            else quiet_step(ev);
        end else if (ph == "RUN") begin
            m_ends = m_ends | s_end;
            if (res_valid) begin
                m_got = 1;
                if (q.size() < 2) q.push_back(int'(res));
            end
            if ((&m_ends) && m_got) begin
                m_fcnt = (m_fcnt + 1) % (1 << FW);
                m_ends = '0; m_got = 0; m_quiet = 0;
                if (!m_cont) begin m_done = 1; ph = "DONE"; end
                else if (q.size() == 2) ph = "WAIT";
            end else quiet_step(ev);
        end else if (ph == "WAIT") begin
            if (q.size() < 2) begin ph = "RUN"; m_quiet = 0; end
        end
    endtask

    task automatic compare();
        chk("wload_start", 32'(wload_start), 32'(m_wls));
        chk("stage_en", 32'(stage_en), (ph == "RUN") ? 32'((1 << NS) - 1) : 32'd0);
        chk("busy", 32'(busy), 32'(ph == "WLOAD" || ph == "RUN" || ph == "WAIT"));
        chk("done", 32'(done), 32'(m_done));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("frame_cnt", 32'(fcnt), 32'(m_fcnt));
        chk("res_valid", 32'(res_o_valid), 32'(q.size() > 0));
        chk("res", 32'(res_o), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    endtask

    // Model follows the DUT on every falling edge: compare the current cycle, then advance
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else begin
            compare();
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        start = 0; abort = 0; wload_done = 0; s_end = '0; res_valid = 0;
    endtask

    task automatic go(input bit c);
        cont = c; start = 1;
        step();
        clr();
    endtask

    initial begin
        int dens;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(stage_en), 0);
        chk("rst_res_valid", 32'(res_o_valid), 0);
        rst_n = 1;
        step();

        // single-shot frame
        act = '0;
        go(0);
        chk("s1_wload_start", 32'(wload_start), 1);
        start = 1; step(); start = 0;
        chk("s1_start_ignored", 32'(wload_start), 0);
        chk("s1_busy", 32'(busy), 1);
        repeat (8) step();
        wload_done = 1; step(); wload_done = 0;
        chk("s1_en", 32'(stage_en), 32'h1f);
        act = 5'h01;
        for (int k = 0; k < NS; k++) begin
            s_end = 5'b1 << k; step();
        end
        s_end = '0;
        res = 5'd7; res_valid = 1; step(); res_valid = 0;
        chk("s1_done", 32'(done), 1);
        chk("s1_en_off", 32'(stage_en), 0);
        chk("s1_fcnt", 32'(fcnt), 1);
        chk("s1_res", 32'(res_o), 7);
        step();
        chk("s1_done_pulse", 32'(done), 0);
        chk("s1_res_hold", 32'(res_o), 7);
        ready = 1; step(); ready = 0;
        chk("s1_popped", 32'(res_o_valid), 0);

        // continuous mode with a stalled consumer
        go(1); wload_done = 1; step(); clr();
        for (int f = 1; f <= 2; f++) begin
            s_end = 5'h1f; res = RW'(f); res_valid = 1; step(); clr();
        end
        chk("s2_wait_en", 32'(stage_en), 0);
        chk("s2_wait_busy", 32'(busy), 1);
        chk("s2_fcnt", 32'(fcnt), 2);
        step();
        chk("s2_still_wait", 32'(stage_en), 0);
        ready = 1;
        chk("s2_head1", 32'(res_o), 1);
        step(); ready = 0;
        chk("s2_resume", 32'(stage_en), 32'h1f);
        s_end = 5'h1f; res = 5'd3; res_valid = 1; step(); clr();
        chk("s2_wait2", 32'(stage_en), 0);
        chk("s2_fcnt3", 32'(fcnt), 3);
        ready = 1;
        chk("s2_head2", 32'(res_o), 2);
        step();
        chk("s2_head3", 32'(res_o), 3);
        step(); ready = 0;
        chk("s2_empty", 32'(res_o_valid), 0);
        abort = 1; step(); abort = 0;
        chk("s2_abort_idle", 32'(busy), 0);

        // result before the last end, then ends before the result
        ready = 1;
        go(0); wload_done = 1; step(); clr();
        res = 5'd3; res_valid = 1; step(); res_valid = 0;
        for (int k = 0; k < 4; k++) begin
            s_end = 5'b1 << k; step();
        end
        s_end = 5'h01; step(); s_end = '0;
        chk("s3a_not_done", 32'(busy), 1);
        chk("s3a_fcnt0", 32'(fcnt), 0);
        s_end = 5'h10; step(); s_end = '0;
        chk("s3a_done", 32'(done), 1);
        chk("s3a_fcnt", 32'(fcnt), 1);
        go(0); wload_done = 1; step(); clr();
        s_end = 5'h1f; step(); s_end = '0; step();
        chk("s3b_waiting", 32'(busy), 1);
        res = 5'd6; res_valid = 1; step(); res_valid = 0;
        chk("s3b_done", 32'(done), 1);
        chk("s3b_fcnt", 32'(fcnt), 1);
        step();
        chk("s3b_once", 32'(done), 0);

        // abort with one buffered result and partial end flags
        ready = 0;
        go(0); wload_done = 1; step(); clr();
        res = 5'd9; res_valid = 1; s_end = 5'h07; step(); clr();
        chk("s4_buffered", 32'(res_o_valid), 1);
        abort = 1; step(); abort = 0;
        chk("s4_flushed", 32'(res_o_valid), 0);
        chk("s4_busy", 32'(busy), 0);
        chk("s4_en", 32'(stage_en), 0);
        go(0); wload_done = 1; step(); clr();
        s_end = 5'h1f; res = 5'd4; res_valid = 1; step(); clr();
        chk("s4_done", 32'(done), 1);
        chk("s4_fcnt", 32'(fcnt), 1);
        chk("s4_res", 32'(res_o), 4);
        ready = 1; step(); ready = 0;

        // watchdog expiry after 15 silent RUN cycles
        go(0); wload_done = 1; step(); clr();
        act = '0;
        repeat (14) step();
        chk("s5_pre", 32'(timeout), 0);
        chk("s5_pre_busy", 32'(busy), 1);
        step();
        chk("s5_tmo", 32'(timeout), 1);
        chk("s5_en", 32'(stage_en), 0);
        chk("s5_busy", 32'(busy), 0);
        go(0);
        chk("s5_clear", 32'(timeout), 0);
        act = 5'h01;
        abort = 1; step(); abort = 0;

        // asynchronous reset in the middle of RUN
        go(1); wload_done = 1; step(); clr();
        s_end = 5'h1f; res = 5'd11; res_valid = 1; step(); clr();
        chk("s6_run", 32'(stage_en), 32'h1f);
        chk("s6_fcnt", 32'(fcnt), 1);
        #2 rst_n = 0;
        #1;
        chk("s6_rst_en", 32'(stage_en), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_fcnt", 32'(fcnt), 0);
        chk("s6_rst_rv", 32'(res_o_valid), 0);
        chk("s6_rst_res", 32'(res_o), 0);
        step();
        rst_n = 1;
        step();

        // randomized traffic with varying event density
        dens = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) dens = $urandom_range(2, 30);
            start = $urandom_range(0, 11) == 0;
            cont = 1'($urandom_range(0, 1));
            abort = $urandom_range(0, 79) == 0;
            wload_done = $urandom_range(0, dens) == 0;
            act = ($urandom_range(0, dens) == 0) ? NS'($urandom) : '0;
            for (int b = 0; b < NS; b++) s_end[b] = $urandom_range(0, dens) == 0;
            res_valid = $urandom_range(0, 5) == 0;
            res = RW'($urandom);
            ready = $urandom_range(0, 2) != 0;
            step();
        end
        clr();
        act = '0;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
